// File: rtl/dm_timer.sv
// Memory-mapped prescaled timer with compare match, auto-reload or halt-on-match,
// and a level interrupt. Eight-word register window on the core data bus.
module dm_timer #(
  parameter logic [63:0] BASE_ADDR = 64'h400
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_dm_addr,
  input  logic        i_dm_cs,
  input  logic        i_dm_rw,
  input  logic [63:0] i_dm_data,
  output logic [63:0] o_dm_data,
  output logic        o_dm_sel,
  output logic        o_irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        ctrl_auto, ctrl_ie;
  logic [63:0] prescale, compare, count, prescaler;
  logic        match;

  logic [63:0] prescaler_nxt, count_nxt, rd_value;
  logic        match_nxt;

  logic        hit, wr, rd;
  logic [2:0]  offset;
  logic        wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
  logic        tick, cmp_hit;

  assign hit    = i_dm_cs && (i_dm_addr[63:3] == BASE_ADDR[63:3]);
  assign offset = i_dm_addr[2:0];
  assign wr     = hit && i_dm_rw;
  assign rd     = hit && !i_dm_rw;

  assign wr_ctrl     = wr && (offset == 3'd0);
  assign wr_prescale = wr && (offset == 3'd1);
  assign wr_compare  = wr && (offset == 3'd2);
  assign wr_count    = wr && (offset == 3'd3);
  assign wr_status   = wr && (offset == 3'd4);

  // EN is not stored separately: it is exactly "the FSM is in RUN".
  assign tick    = (state == RUN) && (prescaler == prescale);
  assign cmp_hit = tick && (count == compare);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (wr_ctrl && i_dm_data[0]) state_nxt = RUN;
      RUN: begin
        if (wr_ctrl)                      state_nxt = i_dm_data[0] ? RUN : IDLE;
        else if (cmp_hit && !ctrl_auto)   state_nxt = HALT;
      end
      HALT: if (wr_ctrl) state_nxt = i_dm_data[0] ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Software writes to COUNT override the tick update; MATCH set beats software clear.
  always_comb begin
    prescaler_nxt = prescaler;
    count_nxt     = count;
    match_nxt     = match;
    if (tick)
      prescaler_nxt = 64'd0;
    else if (state == RUN)
      prescaler_nxt = prescaler + 64'd1;
    if (tick) begin
      if (cmp_hit) begin
        if (ctrl_auto) count_nxt = 64'd0;
      end else begin
        count_nxt = count + 64'd1;
      end
    end
    if (wr_count)
      count_nxt = i_dm_data;
    if (wr_status && i_dm_data[0])
      match_nxt = 1'b0;
    if (cmp_hit)
      match_nxt = 1'b1;
  end

  always_comb begin
    rd_value = 64'd0;
    case (offset)
      3'd0:    rd_value = {61'd0, ctrl_ie, ctrl_auto, (state == RUN)};
      3'd1:    rd_value = prescale;
      3'd2:    rd_value = compare;
      3'd3:    rd_value = count;
      3'd4:    rd_value = {63'd0, match};
      default: rd_value = 64'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      ctrl_auto <= 1'b0;
      ctrl_ie   <= 1'b0;
      prescale  <= 64'd0;
      compare   <= 64'd0;
      count     <= 64'd0;
      prescaler <= 64'd0;
      match     <= 1'b0;
      o_dm_data <= 64'd0;
      o_dm_sel  <= 1'b0;
      o_irq     <= 1'b0;
    end else begin
      state     <= state_nxt;
      prescaler <= prescaler_nxt;
      count     <= count_nxt;
      match     <= match_nxt;
      if (wr_ctrl) begin
        ctrl_auto <= i_dm_data[1];
        ctrl_ie   <= i_dm_data[2];
      end
      if (wr_prescale) prescale <= i_dm_data;
      if (wr_compare)  compare  <= i_dm_data;
      o_dm_sel  <= rd;
      o_dm_data <= rd ? rd_value : 64'd0;
      o_irq     <= match && ctrl_ie;
    end
  end

endmodule
